// File: rtl/upg_word_loader.sv
// UART byte stream to word-wide memory programming writes: a 2-byte length
// header, then little-endian 32-bit words, each written with a one-cycle strobe.
module upg_word_loader #(
    parameter int ADDR_WIDTH     = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  upg_clk_i,
    input  logic                  upg_rst_n_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  upg_wen_o,
    output logic [ADDR_WIDTH-1:0] upg_adr_o,
    output logic [31:0]           upg_dat_o,
    output logic                  upg_done_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [2:0]            dbg_state_o
);

    // Handshake: rx_valid_i is a one-cycle strobe with no back-pressure; every
    // strobe is consumed on the edge that samples it, including a strobe that
    // lands in a write-pulse cycle.
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    // Compare one below the limit so the counter "reaches" TIMEOUT_CYCLES-1 on
    // the same edge that enters ERR.
    localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t                state;
    logic [7:0]            len_lo;
    logic [ADDR_WIDTH-1:0] n_words;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_idx;
    logic [23:0]           part;
    logic [TW-1:0]         to_cnt;

    logic [15:0]           hdr;
    logic                  hdr_bad;
    logic                  timed_out;
    logic                  last_word;

    always_comb begin
        hdr       = {rx_data_i, len_lo};
        hdr_bad   = (hdr >> ADDR_WIDTH) != 16'd0;
        timed_out = !rx_valid_i && (to_cnt == TO_TERM);
        last_word = (word_idx + ADDR_WIDTH'(1)) == n_words;
    end

    assign dbg_state_o = state;

    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            state      <= S_HDR0;
            len_lo     <= 8'd0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_idx   <= 2'd0;
            part       <= 24'd0;
            to_cnt     <= '0;
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= 32'd0;
            upg_done_o <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            upg_wen_o <= 1'b0;
            if ((state == S_HDR1 || state == S_DATA) && !rx_valid_i)
                to_cnt <= to_cnt + TW'(1);
            else
                to_cnt <= '0;

            case (state)
                S_HDR0: begin
                    if (rx_valid_i) begin
                        len_lo <= rx_data_i;
                        busy_o <= 1'b1;
                        state  <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (rx_valid_i) begin
                        if (hdr_bad) begin
                            err_o  <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= S_ERR;
                        end else if (hdr[ADDR_WIDTH-1:0] == '0) begin
                            upg_done_o <= 1'b1;
                            busy_o     <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            n_words  <= hdr[ADDR_WIDTH-1:0];
                            word_idx <= '0;
                            byte_idx <= 2'd0;
                            state    <= S_DATA;
                        end
                    end else if (timed_out) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_ERR;
                    end
                end
                S_DATA: begin
                    if (rx_valid_i) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: part[7:0]   <= rx_data_i;
                            2'd1: part[15:8]  <= rx_data_i;
                            2'd2: part[23:16] <= rx_data_i;
                            default: begin
                                upg_dat_o <= {rx_data_i, part};
                                upg_adr_o <= word_idx;
                                upg_wen_o <= 1'b1;
                                word_idx  <= word_idx + ADDR_WIDTH'(1);
                                if (last_word) begin
                                    busy_o <= 1'b0;
                                    state  <= S_DONE;
                                end
                            end
                        endcase
                    end else if (timed_out) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_ERR;
                    end
                end
                S_DONE: upg_done_o <= 1'b1;
                S_ERR:  err_o      <= 1'b1;
                default: state <= S_HDR0;
            endcase
        end
    end

endmodule

// File: doc/upg_word_loader.md
Name: upg_word_loader

Overview:
- Upstream feeder for the data-memory programming port: turns the UART receiver's byte stream into word-wide writes on the upg_* interface (write enable, word address, write data, done).
- Runs in the upg_clk_i domain (10 MHz).
- Parses a 2-byte length header, assembles little-endian 32-bit words, issues one write strobe per word, then raises done so memory can hand control back to the CPU.

Parameters:
ADDR_WIDTH, 14, word-address width of upg_adr_o; header word count is also ADDR_WIDTH bits
TIMEOUT_CYCLES, 1000000, max idle upg_clk_i cycles between bytes once a session has started (100 ms at 10 MHz)

Ports:
upg_clk_i  input  1  programming clock; all logic on rising edge
upg_rst_n_i  input  1  asynchronous active-low reset
rx_data_i  input  8  received UART byte
rx_valid_i  input  1  one-cycle strobe, rx_data_i valid
upg_wen_o  output  1  one-cycle write strobe to memory
upg_adr_o  output  ADDR_WIDTH  word address of current write
upg_dat_o  output  32  assembled write word
upg_done_o  output  1  high once all N words written; held
busy_o  output  1  high in HDR1 and DATA
err_o  output  1  sticky error flag (bad header or byte timeout)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting upg_rst_n_i forces state HDR0.
  - Clears all outputs to 0: wen, adr, dat, done, busy, err.
  - Clears byte index, word counter and timeout counter.
  - Reset mid-session discards any partial word; no write strobe is issued.
- All outputs are registered.
- HDR0:
  - Waits indefinitely; no timeout.
  - On rx_valid_i, latch count low byte and go to HDR1.
- HDR1:
  - On rx_valid_i, N = {rx_data_i[ADDR_WIDTH-9:0], low byte}.
  - If any rx_data_i bit above ADDR_WIDTH-9 is set, go to ERR.
  - Else if N==0, go to DONE.
  - Else go to DATA with byte index 0 and word index 0.
- DATA:
  - Byte k of a word (k=0..3) fills bits [8k+7:8k]; little-endian.
  - On the 4th byte's rx_valid_i cycle, the next edge loads upg_dat_o with the full word and upg_adr_o with the word index, and pulses upg_wen_o for exactly one cycle.
  - upg_adr_o and upg_dat_o stay stable until the next write.
  - Word index increments after the pulse.
  - When the write of word N-1 is pulsed, the next state is DONE; upg_done_o rises the cycle after that wen pulse.
- Write latency: wen is high in the cycle immediately after the 4th byte strobe.
- An rx_valid_i coinciding with a wen-pulse cycle is accepted as byte 0 of the next word; no byte is lost.
- Timeout:
  - Counter is active in HDR1 and DATA only.
  - It clears on every rx_valid_i and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 with no byte moves the block to ERR; no write is issued for the partial word.
  - An rx_valid_i in the same cycle as the terminal count wins: the byte is accepted and there is no error.
- DONE:
  - upg_done_o=1, busy_o=0.
  - All further bytes are ignored; no more writes.
  - Exit only by reset.
- ERR:
  - err_o=1, upg_done_o=0, busy_o=0.
  - Bytes are ignored; exit only by reset.
  - Memory therefore stays in programming mode until the operator resets and resends.
- busy_o is 1 exactly in HDR1 and DATA.
- Arithmetic: word index counter is ADDR_WIDTH bits. It never wraps, because N ≤ 2^ADDR_WIDTH-1, so the max address is N-1.

Test Plan:
- Nominal load:
  - Stimulus: bytes 02 00 78 56 34 12 EF BE AD DE.
  - Response: wen pulse with adr=0, dat=0x12345678 one cycle after byte 0x12; wen pulse with adr=1, dat=0xDEADBEEF; done=1 the cycle after the second pulse; busy=0; err=0.
- Empty image:
  - Stimulus: bytes 00 00.
  - Response: no wen; done=1 one cycle after the 2nd byte.
- Bad header:
  - Stimulus: bytes 05 40 (ADDR_WIDTH=14).
  - Response: err=1, done=0; subsequent bytes produce no wen.
- Timeout:
  - Setup: TIMEOUT_CYCLES=100.
  - Stimulus: bytes 01 00 AA BB, then silence.
  - Response: err=1 at the 99th idle cycle; no wen. A byte arriving exactly at cycle 99 instead suppresses the error.
- Back-to-back and edges:
  - Stimulus: bytes strobed every cycle for N=3.
  - Response: three single-cycle wen pulses at adr 0,1,2, each with the correct data. A strobe coincident with a wen pulse is captured.
- Reset mid-word:
  - Stimulus: header 02 00 + 2 data bytes; assert upg_rst_n_i asynchronously; release; send a fresh session 01 00 11 22 33 44.
  - Response: all outputs 0 during reset with no spurious wen; then one write at adr=0, dat=0x44332211, followed by done=1.
